// File: rtl/axi_uart_slave_if.sv
// axi_uart_slave_if: AXI4 read/write channels plus the TX byte stream of the UART slave
interface axi_uart_slave_if;
    logic [31:0] araddr;
    logic        arvalid;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic [3:0]  rid;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awready;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic [3:0]  bid;
    logic        bvalid;
    logic        bready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport slave (
        input  araddr, arvalid, arid, arlen, arsize, arburst, rready,
        input  awaddr, awvalid, awid, awlen, awsize, awburst,
        input  wdata, wstrb, wlast, wvalid, bready, tx_ready,
        output arready, rdata, rresp, rid, rlast, rvalid,
        output awready, wready, bresp, bid, bvalid, tx_data, tx_valid
    );

    modport master (
        output araddr, arvalid, arid, arlen, arsize, arburst, rready,
        output awaddr, awvalid, awid, awlen, awsize, awburst,
        output wdata, wstrb, wlast, wvalid, bready, tx_ready,
        input  arready, rdata, rresp, rid, rlast, rvalid,
        input  awready, wready, bresp, bid, bvalid, tx_data, tx_valid
    );
endinterface

// File: rtl/axi_uart_slave.sv
// axi_uart_slave: AXI4 slave exposing an 8-byte UART window with a TX byte FIFO and LSR status
module axi_uart_slave #(
    parameter logic [31:0] UART_BASE  = 32'ha00003f8,
    parameter int          FIFO_DEPTH = 4,
    parameter int          RD_LAT     = 2
) (
    input logic clock,
    input logic reset,
    axi_uart_slave_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(RD_LAT) + 1;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} WriteState;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} ReadState;

    function automatic logic isHit(input logic [31:0] addr);
        return addr >= UART_BASE && (addr - UART_BASE) < 32'd8;
    endfunction

    function automatic logic [2:0] offsetOf(input logic [31:0] addr);
        logic [31:0] diff;
        diff = addr - UART_BASE;
        return diff[2:0];
    endfunction

    logic [7:0]  fifoMem [FIFO_DEPTH];
    logic [AW:0] wrPtr, rdPtr;
    logic        fifoFull, fifoEmpty, push, pop;

    WriteState   wState;
    logic        awReady, bValid;
    logic [1:0]  bResp;
    logic [3:0]  bId, awIdQ;
    logic [31:0] awAddrQ;
    logic [7:0]  awLenQ;
    logic        wPushable, wBeat;

    ReadState    rState;
    logic        arReady, rValid, rLast;
    logic [63:0] rData, rdWord;
    logic [1:0]  rResp, rdResp;
    logic [3:0]  rId, arIdQ;
    logic [31:0] arAddrQ;
    logic [7:0]  arLenQ, rBeat;
    logic [CW-1:0] rCnt;
    logic        rdHit;
    logic        unusedBits;

    assign fifoEmpty = wrPtr == rdPtr;
    assign fifoFull  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign pop       = !fifoEmpty && bus.tx_ready;
    assign bus.tx_valid = !fifoEmpty;
    assign bus.tx_data  = fifoMem[rdPtr[AW-1:0]];

    // Only a single-beat byte write to offset 0 with lane 0 enabled reaches the FIFO.
    assign wPushable = isHit(awAddrQ) && offsetOf(awAddrQ) == 3'd0 && awLenQ == 8'd0 && bus.wstrb[0];
    assign bus.wready = wState == W_DATA && !(fifoFull && wPushable);
    assign wBeat      = bus.wvalid && bus.wready;
    assign push       = wBeat && wPushable;

    assign bus.awready = awReady;
    assign bus.bvalid  = bValid;
    assign bus.bresp   = bResp;
    assign bus.bid     = bId;

    assign rdHit  = isHit(arAddrQ);
    assign rdWord = (rdHit && arLenQ == 8'd0 && offsetOf(arAddrQ) == 3'd5) ? {16'b0, 1'b0, fifoEmpty, !fifoFull, 5'b0, 40'b0} : 64'b0;
    assign rdResp = !rdHit ? 2'b11 : arLenQ != 8'd0 ? 2'b10 : 2'b00;

    assign bus.arready = arReady;
    assign bus.rvalid  = rValid;
    assign bus.rdata   = rData;
    assign bus.rresp   = rResp;
    assign bus.rid     = rId;
    assign bus.rlast   = rLast;

    assign unusedBits = ^{bus.arsize, bus.arburst, bus.awsize, bus.awburst, bus.wdata[63:8], bus.wstrb[7:1]};

    // TX FIFO pointers; the extra MSB distinguishes full from empty.
    always_ff @(posedge clock) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop) rdPtr <= rdPtr + 1'b1;
        end
    end

    // TX FIFO storage; contents are meaningless while the pointers say empty.
    always_ff @(posedge clock) begin
        if (push) fifoMem[wrPtr[AW-1:0]] <= bus.wdata[7:0];
    end

    // Write FSM: accept address, consume beats until wlast, then hold the response until bready.
    always_ff @(posedge clock) begin
        if (reset) begin
            wState  <= W_IDLE;
            awReady <= 1'b1;
            bValid  <= 1'b0;
            bResp   <= 2'b00;
            bId     <= 4'd0;
            awIdQ   <= 4'd0;
            awAddrQ <= 32'd0;
            awLenQ  <= 8'd0;
        end else begin
            case (wState)
                W_IDLE: if (awReady && bus.awvalid) begin
                    wState  <= W_DATA;
                    awReady <= 1'b0;
                    awIdQ   <= bus.awid;
                    awAddrQ <= bus.awaddr;
                    awLenQ  <= bus.awlen;
                end
                W_DATA: if (wBeat && bus.wlast) begin
                    wState <= W_RESP;
                    bValid <= 1'b1;
                    bId    <= awIdQ;
                    bResp  <= !isHit(awAddrQ) ? 2'b11 : awLenQ != 8'd0 ? 2'b10 : 2'b00;
                end
                W_RESP: if (bus.bready) begin
                    wState  <= W_IDLE;
                    bValid  <= 1'b0;
                    awReady <= 1'b1;
                end
                default: wState <= W_IDLE;
            endcase
        end
    end

    // Read FSM: fixed latency wait, then arlen+1 beats whose payload is captured on entry to R_DATA.
    always_ff @(posedge clock) begin
        if (reset) begin
            rState  <= R_IDLE;
            arReady <= 1'b1;
            rValid  <= 1'b0;
            rData   <= 64'd0;
            rResp   <= 2'b00;
            rId     <= 4'd0;
            rLast   <= 1'b0;
            arIdQ   <= 4'd0;
            arAddrQ <= 32'd0;
            arLenQ  <= 8'd0;
            rBeat   <= 8'd0;
            rCnt    <= '0;
        end else begin
            case (rState)
                R_IDLE: if (arReady && bus.arvalid) begin
                    rState  <= R_WAIT;
                    arReady <= 1'b0;
                    arIdQ   <= bus.arid;
                    arAddrQ <= bus.araddr;
                    arLenQ  <= bus.arlen;
                    rCnt    <= CW'(RD_LAT - 1);
                    rBeat   <= 8'd0;
                end
                R_WAIT: if (rCnt == '0) begin
                    rState <= R_DATA;
                    rValid <= 1'b1;
                    rId    <= arIdQ;
                    rLast  <= arLenQ == 8'd0;
                    rData  <= rdWord;
                    rResp  <= rdResp;
                end else begin
                    rCnt <= rCnt - 1'b1;
                end
                R_DATA: if (bus.rready) begin
                    if (rLast) begin
                        rState  <= R_IDLE;
                        rValid  <= 1'b0;
                        rLast   <= 1'b0;
                        arReady <= 1'b1;
                    end else begin
                        rBeat <= rBeat + 8'd1;
                        rLast <= rBeat + 8'd1 == arLenQ;
                    end
                end
                default: rState <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_uart_slave.sv
// tb_axi_uart_slave: scenario and randomized checks of the AXI UART slave against a queue model
module tb_axi_uart_slave;
    localparam logic [31:0] BASE = 32'ha00003f8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int tests = 0;
    int fails = 0;
    logic [7:0] model[$];

    logic [63:0] rdData [16];
    logic [1:0]  rdResp [16];
    logic        rdLast [16];
    logic        rdValid [16];
    logic [3:0]  rdId [16];
    int          rdLatency;
    bit          rdStable;

    axi_uart_slave_if bus();

    axi_uart_slave #(.UART_BASE(BASE), .FIFO_DEPTH(4), .RD_LAT(2)) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    function automatic bit modelHit(input logic [31:0] a);
        return longint'(a) >= longint'(BASE) && longint'(a) < longint'(BASE) + 8;
    endfunction

    function automatic int modelOff(input logic [31:0] a);
        return int'(longint'(a) - longint'(BASE));
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idleInputs();
        bus.araddr = 32'd0; bus.arvalid = 1'b0; bus.arid = 4'd0; bus.arlen = 8'd0; bus.arsize = 3'd0; bus.arburst = 2'd0;
        bus.rready = 1'b0;
        bus.awaddr = 32'd0; bus.awvalid = 1'b0; bus.awid = 4'd0; bus.awlen = 8'd0; bus.awsize = 3'd0; bus.awburst = 2'd0;
        bus.wdata = 64'd0; bus.wstrb = 8'd0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
        bus.bready = 1'b0; bus.tx_ready = 1'b0;
    endtask

    task automatic awPhase(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id, output bit timeout);
        bus.awaddr = addr; bus.awlen = len; bus.awid = id;
        bus.awsize = 3'($urandom); bus.awburst = 2'($urandom); bus.awvalid = 1'b1;
        timeout = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (bus.awready) begin timeout = 1'b0; break; end
            tick();
        end
        tick();
        bus.awvalid = 1'b0;
    endtask

    task automatic wBeat(input logic [63:0] data, input logic [7:0] strb, input logic last, output bit timeout);
        bus.wdata = data; bus.wstrb = strb; bus.wlast = last; bus.wvalid = 1'b1;
        #1;
        timeout = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (bus.wready) begin timeout = 1'b0; break; end
            tick();
        end
        tick();
        bus.wvalid = 1'b0; bus.wlast = 1'b0;
    endtask

    task automatic bPhase(output bit timeout);
        timeout = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (bus.bvalid) begin timeout = 1'b0; break; end
            tick();
        end
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
    endtask

    task automatic arPhase(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id, output bit timeout);
        bus.araddr = addr; bus.arlen = len; bus.arid = id;
        bus.arsize = 3'($urandom); bus.arburst = 2'($urandom); bus.arvalid = 1'b1;
        timeout = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (bus.arready) begin timeout = 1'b0; break; end
            tick();
        end
        tick();
        bus.arvalid = 1'b0;
    endtask

    task automatic rCollect(input int beats, input bit stall);
        rdLatency = 0;
        while (!bus.rvalid && rdLatency < 50) begin
            tick();
            rdLatency++;
        end
        rdStable = 1'b1;
        for (int b = 0; b < beats; b++) begin
            rdValid[b] = bus.rvalid; rdData[b] = bus.rdata; rdResp[b] = bus.rresp; rdLast[b] = bus.rlast; rdId[b] = bus.rid;
            if (stall) begin
                tick();
                if ({bus.rvalid, bus.rdata, bus.rresp, bus.rlast, bus.rid} !== {rdValid[b], rdData[b], rdResp[b], rdLast[b], rdId[b]}) rdStable = 1'b0;
            end
            bus.rready = 1'b1;
            tick();
            bus.rready = 1'b0;
        end
    endtask

    task automatic test_reset();
        idleInputs();
        reset = 1'b1;
        repeat (3) tick();
        tests++; if ({bus.arready, bus.awready} !== 2'b11) begin fails++; $display("FAIL reset_ready got ar/aw=%b want 11", {bus.arready, bus.awready}); end
        tests++; if ({bus.rvalid, bus.bvalid, bus.wready, bus.tx_valid} !== 4'b0000) begin fails++; $display("FAIL reset_valids got r/b/w/tx=%b want 0000", {bus.rvalid, bus.bvalid, bus.wready, bus.tx_valid}); end
        tests++; if ({bus.rdata, bus.rresp, bus.rid, bus.rlast, bus.bresp, bus.bid} !== 77'd0) begin fails++; $display("FAIL reset_payload got rdata=%h rresp=%b rid=%h rlast=%b bresp=%b bid=%h want all 0", bus.rdata, bus.rresp, bus.rid, bus.rlast, bus.bresp, bus.bid); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_drain(input int cycles);
        bit valid;
        bus.tx_ready = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            valid = model.size() != 0;
            tests++; if (bus.tx_valid !== valid) begin fails++; $display("FAIL drain_valid got %b want %b", bus.tx_valid, valid); end
            if (valid) begin
                tests++; if (bus.tx_data !== model[0]) begin fails++; $display("FAIL drain_data got %h want %h", bus.tx_data, model[0]); end
            end
            tick();
            if (valid) void'(model.pop_front());
        end
        bus.tx_ready = 1'b0;
    endtask

    task automatic test_uart_write();
        bit to;
        awPhase(BASE, 8'd0, 4'd5, to);
        bus.wdata = {$urandom, 24'($urandom), 8'h41}; bus.wstrb = 8'h01; bus.wlast = 1'b1; bus.wvalid = 1'b1;
        #1;
        tests++; if ({to, bus.wready, bus.tx_valid} !== 3'b010) begin fails++; $display("FAIL write_pre got timeout/wready/tx_valid=%b want 010", {to, bus.wready, bus.tx_valid}); end
        tick();
        bus.wvalid = 1'b0; bus.wlast = 1'b0;
        tests++; if ({bus.bvalid, bus.bresp, bus.bid} !== {1'b1, 2'b00, 4'd5}) begin fails++; $display("FAIL write_bresp got bvalid=%b bresp=%b bid=%h want 1 00 5", bus.bvalid, bus.bresp, bus.bid); end
        tests++; if ({bus.tx_valid, bus.tx_data} !== {1'b1, 8'h41}) begin fails++; $display("FAIL write_tx got valid=%b data=%h want 1 41", bus.tx_valid, bus.tx_data); end
        model.push_back(8'h41);
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        tests++; if ({bus.bvalid, bus.awready} !== 2'b01) begin fails++; $display("FAIL write_done got bvalid/awready=%b want 01", {bus.bvalid, bus.awready}); end
    endtask

    task automatic test_fifo_full();
        bit to;
        bit stalled;
        for (int i = 0; i < 4; i++) begin
            awPhase(BASE, 8'd0, 4'(i), to);
            wBeat({56'd0, 8'(8'h30 + i)}, 8'h01, 1'b1, to);
            tests++; if ({to, bus.bvalid, bus.bresp} !== 4'b0100) begin fails++; $display("FAIL full_write%0d got timeout/bvalid/bresp=%b want 0100", i, {to, bus.bvalid, bus.bresp}); end
            bPhase(to);
            model.push_back(8'(8'h30 + i));
        end
        awPhase(BASE, 8'd0, 4'd4, to);
        bus.wdata = 64'h34; bus.wstrb = 8'h01; bus.wlast = 1'b1; bus.wvalid = 1'b1;
        #1;
        stalled = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if (bus.wready !== 1'b0) stalled = 1'b0;
            tick();
        end
        tests++; if (stalled !== 1'b1 || bus.bvalid !== 1'b0) begin fails++; $display("FAIL full_stall got stalled=%b bvalid=%b want 1 0", stalled, bus.bvalid); end
        bus.tx_ready = 1'b1;
        tests++; if ({bus.tx_valid, bus.tx_data} !== {1'b1, 8'h30}) begin fails++; $display("FAIL full_pop got valid=%b data=%h want 1 30", bus.tx_valid, bus.tx_data); end
        tick();
        bus.tx_ready = 1'b0;
        void'(model.pop_front());
        tests++; if (bus.wready !== 1'b1) begin fails++; $display("FAIL full_release got wready=%b want 1", bus.wready); end
        tick();
        bus.wvalid = 1'b0; bus.wlast = 1'b0;
        tests++; if ({bus.bvalid, bus.bresp, bus.bid} !== {1'b1, 2'b00, 4'd4}) begin fails++; $display("FAIL full_fifth got bvalid=%b bresp=%b bid=%h want 1 00 4", bus.bvalid, bus.bresp, bus.bid); end
        bPhase(to);
        model.push_back(8'h34);
    endtask

    task automatic test_lsr_read();
        bit to;
        arPhase(BASE + 32'd5, 8'd0, 4'hA, to);
        rCollect(1, 1'b0);
        tests++; if (rdLatency !== 2 || to) begin fails++; $display("FAIL lsr_latency got %0d want 2", rdLatency); end
        tests++; if ({rdValid[0], rdData[0], rdResp[0], rdLast[0], rdId[0]} !== {1'b1, 64'h0000_6000_0000_0000, 2'b00, 1'b1, 4'hA}) begin fails++; $display("FAIL lsr_beat got v=%b data=%h resp=%b last=%b id=%h want 1 0000600000000000 00 1 a", rdValid[0], rdData[0], rdResp[0], rdLast[0], rdId[0]); end
        tests++; if ({bus.rvalid, bus.arready} !== 2'b01) begin fails++; $display("FAIL lsr_done got rvalid/arready=%b want 01", {bus.rvalid, bus.arready}); end
    endtask

    task automatic test_decerr();
        bit to;
        arPhase(32'h8000_0000, 8'd0, 4'h3, to);
        rCollect(1, 1'b1);
        tests++; if ({rdValid[0], rdData[0], rdResp[0], rdLast[0], rdId[0], rdStable} !== {1'b1, 64'd0, 2'b11, 1'b1, 4'h3, 1'b1}) begin fails++; $display("FAIL decerr_read got v=%b data=%h resp=%b last=%b id=%h stable=%b want 1 0 11 1 3 1", rdValid[0], rdData[0], rdResp[0], rdLast[0], rdId[0], rdStable); end
        awPhase(32'h8000_0000, 8'd0, 4'h6, to);
        wBeat(64'h99, 8'hff, 1'b1, to);
        tests++; if ({to, bus.bvalid, bus.bresp, bus.bid} !== {1'b0, 1'b1, 2'b11, 4'h6}) begin fails++; $display("FAIL decerr_write got timeout=%b bvalid=%b bresp=%b bid=%h want 0 1 11 6", to, bus.bvalid, bus.bresp, bus.bid); end
        bPhase(to);
        tests++; if (bus.tx_valid !== (model.size() != 0)) begin fails++; $display("FAIL decerr_fifo got tx_valid=%b want %b", bus.tx_valid, model.size() != 0); end
    endtask

    task automatic test_burst();
        bit to;
        awPhase(BASE, 8'd1, 4'h7, to);
        wBeat(64'h11, 8'h01, 1'b0, to);
        tests++; if ({to, bus.bvalid} !== 2'b00) begin fails++; $display("FAIL burst_first got timeout/bvalid=%b want 00", {to, bus.bvalid}); end
        wBeat(64'h22, 8'h01, 1'b1, to);
        tests++; if ({to, bus.bvalid, bus.bresp, bus.tx_valid} !== {1'b0, 1'b1, 2'b10, 1'b0}) begin fails++; $display("FAIL burst_write got timeout=%b bvalid=%b bresp=%b tx_valid=%b want 0 1 10 0", to, bus.bvalid, bus.bresp, bus.tx_valid); end
        bPhase(to);
        arPhase(BASE + 32'd5, 8'd2, 4'h9, to);
        rCollect(3, 1'b1);
        tests++; if (rdLatency !== 2 || !rdStable) begin fails++; $display("FAIL burst_read_timing got latency=%0d stable=%b want 2 1", rdLatency, rdStable); end
        for (int b = 0; b < 3; b++) begin
            tests++; if ({rdValid[b], rdData[b], rdResp[b], rdLast[b], rdId[b]} !== {1'b1, 64'd0, 2'b10, b == 2, 4'h9}) begin fails++; $display("FAIL burst_beat%0d got v=%b data=%h resp=%b last=%b id=%h want 1 0 10 %b 9", b, rdValid[b], rdData[b], rdResp[b], rdLast[b], rdId[b], b == 2); end
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        bit sawValid;
        awPhase(BASE, 8'd0, 4'd3, to);
        wBeat(64'h55, 8'h01, 1'b1, to);
        arPhase(BASE + 32'd5, 8'd0, 4'd2, to);
        tests++; if ({bus.bvalid, bus.tx_valid, bus.rvalid, bus.arready} !== 4'b1100) begin fails++; $display("FAIL midreset_pre got bvalid/tx_valid/rvalid/arready=%b want 1100", {bus.bvalid, bus.tx_valid, bus.rvalid, bus.arready}); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model.delete();
        tests++; if ({bus.arready, bus.awready, bus.rvalid, bus.bvalid, bus.tx_valid} !== 5'b11000) begin fails++; $display("FAIL midreset_post got ar/aw/r/b/tx=%b want 11000", {bus.arready, bus.awready, bus.rvalid, bus.bvalid, bus.tx_valid}); end
        sawValid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (bus.rvalid || bus.bvalid) sawValid = 1'b1;
        end
        tests++; if (sawValid !== 1'b0) begin fails++; $display("FAIL midreset_quiet got late response=%b want 0", sawValid); end
    endtask

    task automatic test_random();
        logic [31:0] addr;
        logic [7:0]  len, strb, lsr;
        logic [63:0] data, expData;
        logic [3:0]  id;
        logic [1:0]  expResp;
        bit to, hit, pushes;
        int off, sel, op;
        for (int n = 0; n < 60; n++) begin
            sel = $urandom_range(0, 4);
            addr = sel == 0 ? BASE : sel == 1 ? BASE + 32'($urandom_range(0, 7)) : sel == 2 ? $urandom : sel == 3 ? BASE + 32'd8 : BASE - 32'd1;
            hit = modelHit(addr);
            off = modelOff(addr);
            id = 4'($urandom);
            data = {$urandom, $urandom};
            strb = 8'($urandom);
            op = $urandom_range(0, 2);
            if (op == 0) begin
                len = $urandom_range(0, 3) == 0 ? 8'd1 : 8'd0;
                expResp = !hit ? 2'b11 : len != 8'd0 ? 2'b10 : 2'b00;
                pushes = hit && off == 0 && len == 8'd0 && strb[0];
                if (pushes && model.size() == 4) test_drain(2);
                awPhase(addr, len, id, to);
                for (int b = 0; b <= int'(len); b++) begin
                    wBeat(data ^ 64'(b), strb, b == int'(len), to);
                    tests++; if (to) begin fails++; $display("FAIL rand_wready got timeout at beat %0d want handshake", b); end
                end
                tests++; if ({bus.bvalid, bus.bresp, bus.bid} !== {1'b1, expResp, id}) begin fails++; $display("FAIL rand_bresp addr=%h got bvalid=%b bresp=%b bid=%h want 1 %b %h", addr, bus.bvalid, bus.bresp, bus.bid, expResp, id); end
                bPhase(to);
                if (pushes) model.push_back(data[7:0]);
                tests++; if (bus.tx_valid !== (model.size() != 0)) begin fails++; $display("FAIL rand_txvalid got %b want %b", bus.tx_valid, model.size() != 0); end
            end else if (op == 1) begin
                len = $urandom_range(0, 1) == 1 ? 8'd0 : 8'($urandom_range(1, 3));
                lsr = (model.size() == 0 ? 8'h40 : 8'h00) | (model.size() < 4 ? 8'h20 : 8'h00);
                expData = (hit && len == 8'd0 && off == 5) ? (64'(lsr) << 40) : 64'd0;
                expResp = !hit ? 2'b11 : len != 8'd0 ? 2'b10 : 2'b00;
                arPhase(addr, len, id, to);
                rCollect(int'(len) + 1, 1'($urandom_range(0, 1)));
                tests++; if (rdLatency !== 2 || !rdStable || to) begin fails++; $display("FAIL rand_rtiming got latency=%0d stable=%b want 2 1", rdLatency, rdStable); end
                for (int b = 0; b <= int'(len); b++) begin
                    tests++; if ({rdValid[b], rdData[b], rdResp[b], rdLast[b], rdId[b]} !== {1'b1, expData, expResp, b == int'(len), id}) begin fails++; $display("FAIL rand_rbeat addr=%h beat=%0d got v=%b data=%h resp=%b last=%b id=%h want 1 %h %b %b %h", addr, b, rdValid[b], rdData[b], rdResp[b], rdLast[b], rdId[b], expData, expResp, b == int'(len), id); end
                end
            end else begin
                test_drain($urandom_range(1, 4));
            end
        end
    endtask

    initial begin
        test_reset();
        test_uart_write();
        test_drain(3);
        test_fifo_full();
        test_drain(6);
        test_lsr_read();
        test_decerr();
        test_burst();
        test_reset_mid();
        test_random();
        test_drain(6);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
